// File: rtl/nibble_ram_arbiter.sv
// Two-requester arbiter in front of a 4Kx4 SRAM: each byte access from A (read/write)
// or B (read-only) becomes a low-nibble cycle followed by a high-nibble cycle.
module nibble_ram_arbiter #(
  parameter int unsigned B_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [10:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [10:0] b_addr,
  output logic [7:0]  b_rdata,
  output logic        b_ack,
  output logic [11:0] ram_addr,
  output logic [3:0]  ram_din,
  input  logic [3:0]  ram_dout,
  output logic        ram_we_b,
  output logic        ram_e_b
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  localparam logic B_WINS = (B_PRIORITY != 0);

  state_t      state, state_nx;
  logic        cur_b, cur_b_nx;
  logic        cur_we, cur_we_nx;
  logic [10:0] cur_addr, cur_addr_nx;
  logic [7:0]  cur_wdata, cur_wdata_nx;
  logic [3:0]  rd_lo, rd_lo_nx;
  logic        last_b, last_b_nx;
  logic [7:0]  a_rdata_nx, b_rdata_nx;
  logic        a_ack_nx, b_ack_nx;
  logic [11:0] ram_addr_nx;
  logic [3:0]  ram_din_nx;
  logic        ram_we_b_nx, ram_e_b_nx;

  logic        a_elig, b_elig, grant_b;
  logic        sel_we;
  logic [10:0] sel_addr;
  logic [7:0]  sel_wdata;

  // A requester still seeing its ack this cycle must not be re-served on this edge.
  assign a_elig = a_req && !a_ack;
  assign b_elig = b_req && !b_ack;

  always_comb begin
    state_nx     = state;
    cur_b_nx     = cur_b;
    cur_we_nx    = cur_we;
    cur_addr_nx  = cur_addr;
    cur_wdata_nx = cur_wdata;
    rd_lo_nx     = rd_lo;
    last_b_nx    = last_b;
    a_rdata_nx   = a_rdata;
    b_rdata_nx   = b_rdata;
    a_ack_nx     = 1'b0;
    b_ack_nx     = 1'b0;
    ram_addr_nx  = ram_addr;
    ram_din_nx   = ram_din;
    ram_we_b_nx  = ram_we_b;
    ram_e_b_nx   = ram_e_b;
    grant_b      = 1'b0;
    sel_we       = 1'b0;
    sel_addr     = '0;
    sel_wdata    = '0;

    case (state)
      IDLE: begin
        ram_e_b_nx  = 1'b1;
        ram_we_b_nx = 1'b1;
        if (a_elig || b_elig) begin
          grant_b   = b_elig && (!a_elig || B_WINS || !last_b);
          sel_we    = grant_b ? 1'b0 : a_we;
          sel_addr  = grant_b ? b_addr : a_addr;
          sel_wdata = grant_b ? 8'h00 : a_wdata;
          cur_b_nx     = grant_b;
          cur_we_nx    = sel_we;
          cur_addr_nx  = sel_addr;
          cur_wdata_nx = sel_wdata;
          last_b_nx    = grant_b;
          ram_e_b_nx   = 1'b0;
          ram_we_b_nx  = ~sel_we;
          ram_addr_nx  = {sel_addr, 1'b0};
          ram_din_nx   = sel_wdata[3:0];
          state_nx     = LO;
        end
      end
      LO: begin
        // Low nibble is buffered internally so rdata only changes with the ack.
        if (!cur_we) rd_lo_nx = ram_dout;
        ram_addr_nx = {cur_addr, 1'b1};
        ram_din_nx  = cur_wdata[7:4];
        state_nx    = HI;
      end
      HI: begin
        ram_e_b_nx  = 1'b1;
        ram_we_b_nx = 1'b1;
        state_nx    = IDLE;
        if (cur_b) begin
          b_ack_nx   = 1'b1;
          b_rdata_nx = {ram_dout, rd_lo};
        end else begin
          a_ack_nx = 1'b1;
          if (!cur_we) a_rdata_nx = {ram_dout, rd_lo};
        end
      end
      default: begin
        ram_e_b_nx  = 1'b1;
        ram_we_b_nx = 1'b1;
        state_nx    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      cur_b     <= 1'b0;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      rd_lo     <= '0;
      last_b    <= 1'b1;
      a_rdata   <= '0;
      b_rdata   <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we_b  <= 1'b1;
      ram_e_b   <= 1'b1;
    end else begin
      state     <= state_nx;
      cur_b     <= cur_b_nx;
      cur_we    <= cur_we_nx;
      cur_addr  <= cur_addr_nx;
      cur_wdata <= cur_wdata_nx;
      rd_lo     <= rd_lo_nx;
      last_b    <= last_b_nx;
      a_rdata   <= a_rdata_nx;
      b_rdata   <= b_rdata_nx;
      a_ack     <= a_ack_nx;
      b_ack     <= b_ack_nx;
      ram_addr  <= ram_addr_nx;
      ram_din   <= ram_din_nx;
      ram_we_b  <= ram_we_b_nx;
      ram_e_b   <= ram_e_b_nx;
    end
  end

endmodule

// File: doc/nibble_ram_arbiter.md
NIBBLE_RAM_ARBITER -- requirements
Module: nibble_ram_arbiter

Interface
REQ-001 The block SHALL have parameter B_PRIORITY, default 0, meaning 0 = round-robin between requesters and 1 = requester B always wins ties.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 a_req  input  1  requester A (CPU) access request, held high until a_ack.
REQ-005 a_we  input  1  A access is a write (1) or read (0).
REQ-006 a_addr  input  11  A byte address.
REQ-007 a_wdata  input  8  A write byte.
REQ-008 a_rdata  output  8  A read byte, valid while a_ack is high.
REQ-009 a_ack  output  1  one-cycle completion pulse for A.
REQ-010 b_req  input  1  requester B (video) read request, held high until b_ack; B is read-only.
REQ-011 b_addr  input  11  B byte address.
REQ-012 b_rdata  output  8  B read byte, valid while b_ack is high.
REQ-013 b_ack  output  1  one-cycle completion pulse for B.
REQ-014 ram_addr  output  12  nibble address to the 4Kx4 SRAM.
REQ-015 ram_din  output  4  write nibble to the SRAM.
REQ-016 ram_dout  input  4  SRAM read nibble, combinationally valid while ram_e_b=0 and ram_we_b=1.
REQ-017 ram_we_b  output  1  SRAM write enable, active-low; the SRAM writes on the rising clk edge when ram_we_b=0 and ram_e_b=0.
REQ-018 ram_e_b  output  1  SRAM chip enable, active-low.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 The block SHALL use FSM states IDLE, LO and HI.
REQ-021 Each byte access SHALL map to two SRAM cycles: the low nibble at {addr,1'b0} in LO, then the high nibble at {addr,1'b1} in HI.
REQ-022 In IDLE, on an edge where an eligible request is pending, the block SHALL latch that requester's addr, we and wdata, then enter LO with ram_e_b=0, ram_we_b=~we, ram_addr={addr,0}, ram_din=wdata[3:0].
REQ-023 LO->HI: on that edge the block SHALL capture ram_dout into rdata[3:0] on a read, and drive ram_addr={addr,1} and ram_din=wdata[7:4].
REQ-024 HI->IDLE: on that edge the block SHALL capture ram_dout into rdata[7:4] on a read, drive ram_e_b=1 and ram_we_b=1, and pulse the granted requester's ack for exactly one cycle.
REQ-025 Latency SHALL be fixed: request sampled at edge N, LO during cycle N+1, HI during N+2, ack high during N+3.
REQ-026 A requester whose ack is high in the current cycle SHALL NOT be eligible on that edge, so that a held req is not double-served.
REQ-027 With B_PRIORITY=0 and both requests eligible, the block SHALL grant the requester not granted last; a single eligible request SHALL always be granted.
REQ-028 With B_PRIORITY=1 and both requests eligible, the block SHALL grant B.
REQ-029 Requests arriving in LO or HI SHALL wait; no transaction SHALL be preempted.
REQ-030 The a_rdata and b_rdata outputs SHALL hold their last value when the corresponding ack is low.
REQ-031 On a write transaction, rdata SHALL be left unchanged.
REQ-032 Byte address 0x7FF SHALL map to nibbles 0xFFE and 0xFFF with no wrap.
REQ-033 ram_we_b SHALL be 0 only while ram_e_b is 0.
REQ-034 ram_e_b SHALL be 1 in every IDLE cycle.

Reset
REQ-035 On rst_b low, the block SHALL asynchronously force: state=IDLE, ram_e_b=1, ram_we_b=1, ram_addr=0, ram_din=0, a_ack=b_ack=0, a_rdata=b_rdata=0, last-grant=B (so A wins the first tie).
REQ-036 Reset asserted mid-transaction SHALL abort it with no ack; a write aborted after LO leaves the low nibble written and the high nibble unchanged, which is accepted behaviour.
REQ-037 After rst_b deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_b high.

Verification
REQ-038 A write a_addr=0x123, a_wdata=0xA5 -> ram_addr 0x246 with din 5 in LO and 0x247 with din A in HI, ram_we_b low in both; a_ack pulses 3 cycles after the request edge.
REQ-039 An A read of 0x123 after the REQ-038 write -> a_rdata=0xA5 while a_ack=1.
REQ-040 With B_PRIORITY=0, a_req and b_req asserted in the same cycle after reset, both held -> A is served first, then B, with back-to-back transactions and no idle LO/HI gap beyond the ack cycle.
REQ-041 With B_PRIORITY=1 and both requesters continuously requesting -> B is granted at every tie; A is served only when b_req is low or ineligible.
REQ-042 A write to 0x7FF with 0x3C -> nibbles 0xFFE=C and 0xFFF=3; a read of 0x7FF returns 0x3C.
REQ-043 rst_b pulsed low during HI of a write -> ram_e_b and ram_we_b go high immediately, no ack is issued, and a subsequent read returns the new low nibble with the old high nibble.
